// File: rtl/nn_control.sv
// nn_control: sequencing controller for the training flow.
// Paces one sample at a time against arch_done and runs a training phase,
// then a validation phase, for every epoch, followed by one weight store.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   go                    run request, sampled only in IDLE
//   TRAIN, VALID, EPOCH   sample/epoch counts from Pattern (stable while busy)
//   arch_done             Architecture finished the current sample (WAIT states)
//   TR, VL, SW            next-train / next-valid / store-weights pulses
//   START, END            run start / run completion pulses
//   train_en              high in the training states
//   busy                  high whenever not IDLE
//   epoch_cnt             current epoch index
//   sample_cnt            current sample index within the phase
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for go
// STRT    | START pulse, clear counters, pick first phase
// T_ISSUE | TR pulse, Pattern advances to next train sample
// T_WAIT  | waiting for arch_done on a training sample
// V_ISSUE | VL pulse, Pattern advances to next valid sample
// V_WAIT  | waiting for arch_done on a validation sample
// STORE   | SW pulse
// FIN     | END pulse
module nn_control #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [BITS-1:0] TRAIN,
    input  logic [BITS-1:0] VALID,
    input  logic [BITS-1:0] EPOCH,
    input  logic            arch_done,
    output logic            TR,
    output logic            VL,
    output logic            SW,
    output logic            START,
    output logic            END,
    output logic            train_en,
    output logic            busy,
    output logic [BITS-1:0] epoch_cnt,
    output logic [BITS-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STRT    = 3'd1,
        T_ISSUE = 3'd2,
        T_WAIT  = 3'd3,
        V_ISSUE = 3'd4,
        V_WAIT  = 3'd5,
        STORE   = 3'd6,
        FIN     = 3'd7
    } state_t;

    localparam logic [BITS-1:0] ONE  = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0] ZERO = '0;

    state_t          state, state_nx;
    logic [BITS-1:0] epoch_nx, sample_nx;
    logic [BITS-1:0] train_m1, valid_m1, epoch_m1;
    state_t          phase0_state, eoe_state;
    logic [BITS-1:0] eoe_epoch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            epoch_cnt  <= ZERO;
            sample_cnt <= ZERO;
        end else begin
            state      <= state_nx;
            epoch_cnt  <= epoch_nx;
            sample_cnt <= sample_nx;
        end
    end

    always_comb begin
        // Minus-one limits are only consulted when the matching count is
        // non-zero, so the underflow for a zero count is never used.
        train_m1     = TRAIN - ONE;
        valid_m1     = VALID - ONE;
        epoch_m1     = EPOCH - ONE;
        phase0_state = (TRAIN != ZERO) ? T_ISSUE : V_ISSUE;

        // End-of-epoch decision, shared by both WAIT states.
        if (epoch_cnt < epoch_m1) begin
            eoe_state = phase0_state;
            eoe_epoch = epoch_cnt + ONE;
        end else begin
            eoe_state = STORE;
            eoe_epoch = epoch_cnt;
        end

        state_nx  = state;
        epoch_nx  = epoch_cnt;
        sample_nx = sample_cnt;

        case (state)
            IDLE: begin
                if (go) state_nx = STRT;
            end
            STRT: begin
                epoch_nx  = ZERO;
                sample_nx = ZERO;
                if (EPOCH == ZERO)      state_nx = STORE;
                else if (TRAIN != ZERO) state_nx = T_ISSUE;
                else if (VALID != ZERO) state_nx = V_ISSUE;
                else                    state_nx = STORE;
            end
            T_ISSUE: state_nx = T_WAIT;
            T_WAIT: begin
                if (arch_done) begin
                    if (sample_cnt < train_m1) begin
                        sample_nx = sample_cnt + ONE;
                        state_nx  = T_ISSUE;
                    end else begin
                        sample_nx = ZERO;
                        if (VALID != ZERO) begin
                            state_nx = V_ISSUE;
                        end else begin
                            state_nx = eoe_state;
                            epoch_nx = eoe_epoch;
                        end
                    end
                end
            end
            V_ISSUE: state_nx = V_WAIT;
            V_WAIT: begin
                if (arch_done) begin
                    if (sample_cnt < valid_m1) begin
                        sample_nx = sample_cnt + ONE;
                        state_nx  = V_ISSUE;
                    end else begin
                        sample_nx = ZERO;
                        state_nx  = eoe_state;
                        epoch_nx  = eoe_epoch;
                    end
                end
            end
            STORE:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign START    = (state == STRT);
    assign TR       = (state == T_ISSUE);
    assign VL       = (state == V_ISSUE);
    assign SW       = (state == STORE);
    assign END      = (state == FIN);
    assign train_en = (state == T_ISSUE) || (state == T_WAIT);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_nn_control.sv
// Testbench for nn_control: expected pulse events (kind, cycle, counters)
// are queued before each run and checked as the DUT emits them.
module tb_nn_control;

    localparam int BITS = 16;

    logic            clk, rst, go, arch_done;
    logic [BITS-1:0] TRAIN, VALID, EPOCH;
    logic            TR, VL, SW, START, END, train_en, busy;
    logic [BITS-1:0] epoch_cnt, sample_cnt;

    nn_control #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .go(go),
        .TRAIN(TRAIN), .VALID(VALID), .EPOCH(EPOCH),
        .arch_done(arch_done),
        .TR(TR), .VL(VL), .SW(SW), .START(START), .END(END),
        .train_en(train_en), .busy(busy),
        .epoch_cnt(epoch_cnt), .sample_cnt(sample_cnt)
    );

    localparam int K_START = 1, K_TR = 2, K_VL = 3, K_SW = 4, K_END = 5;

    typedef struct {
        int kind;
        int cyc;
        int ep;
        int smp;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  push_lim, push_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every emitted pulse must match the head of the queue.
    always @(negedge clk) begin
        int  n;
        int  k;
        ev_t e;
        n = int'(START === 1'b1) + int'(TR === 1'b1) + int'(VL === 1'b1)
          + int'(SW === 1'b1) + int'(END === 1'b1);
        if (n > 1) begin
            errors++;
            $display("FAIL onehot cyc=%0d: %0d pulses high, required at most 1", cyc, n);
        end
        if (n >= 1) begin
            k = (START === 1'b1) ? K_START : (TR === 1'b1) ? K_TR :
                (VL === 1'b1) ? K_VL : (SW === 1'b1) ? K_SW : K_END;
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d: kind %0d seen, none required", cyc, k);
            end else begin
                e = sb.pop_front();
                if (k !== e.kind || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse_order: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                             k, cyc, e.kind, e.cyc);
                end else if ((k == K_TR || k == K_VL) &&
                             (int'(epoch_cnt) !== e.ep || int'(sample_cnt) !== e.smp)) begin
                    errors++;
                    $display("FAIL pulse_counters kind %0d cyc %0d: got ep=%0d smp=%0d, required ep=%0d smp=%0d",
                             k, cyc, epoch_cnt, sample_cnt, e.ep, e.smp);
                end
            end
        end
    end

    function automatic void add(input int kind, input int c, input int e, input int s);
        ev_t ev;
        if (push_lim < 0 || push_n < push_lim) begin
            ev.kind = kind; ev.cyc = c; ev.ep = e; ev.smp = s;
            sb.push_back(ev);
            push_n++;
        end
    endfunction

    // Reference schedule: each sample costs 2 + d cycles (issue, d idle waits, accepting wait).
    function automatic void push_run(input int tr, input int va, input int ep,
                                     input int d, input int g, input int lim);
        int t;
        push_lim = lim;
        push_n   = 0;
        add(K_START, g, 0, 0);
        t = g + 1;
        for (int e = 0; e < ep; e++) begin
            for (int s = 0; s < tr; s++) begin add(K_TR, t, e, s); t += 2 + d; end
            for (int s = 0; s < va; s++) begin add(K_VL, t, e, s); t += 2 + d; end
        end
        add(K_SW, t, 0, 0);
        add(K_END, t + 1, 0, 0);
    endfunction

    task automatic do_run(input int tr, input int va, input int ep, input int d,
                          input bit stray, input bit held, input string name);
        int  g, wcnt, busy_n, ten_n, exp_busy, exp_ten;
        bit  started, done;
        @(negedge clk);
        TRAIN = BITS'(tr); VALID = BITS'(va); EPOCH = BITS'(ep);
        g = cyc + 1;
        push_run(tr, va, ep, held ? 0 : d, g, -1);
        go = 1'b1;
        wcnt = -1; busy_n = 0; ten_n = 0; started = 0; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            go = 1'b0;
            if (busy === 1'b1) begin busy_n++; started = 1; end
            else if (started) done = 1;
            if (train_en === 1'b1) ten_n++;
            if (held) arch_done = 1'b1;
            else begin
                arch_done = 1'b0;
                if (TR === 1'b1 || VL === 1'b1) begin
                    wcnt = d;
                    if (stray) arch_done = 1'b1;
                end else if (wcnt == 0) begin
                    arch_done = 1'b1; wcnt = -1;
                end else if (wcnt > 0) wcnt--;
            end
        end
        arch_done = 1'b0;
        exp_busy = 3 + ep * (tr + va) * (2 + (held ? 0 : d));
        if (ep == 0) exp_busy = 3;
        exp_ten  = ep * tr * (2 + (held ? 0 : d));
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: run did not return to IDLE within budget", name);
        end else if (busy_n !== exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_n, exp_busy);
        end
        vectors++;
        if (ten_n !== exp_ten) begin
            errors++;
            $display("FAIL %s train_en_cycles: got %0d, required %0d", name, ten_n, exp_ten);
        end
        vectors++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s missing_pulses: %0d expected pulses not seen, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; arch_done = 1'b0;
        TRAIN = '0; VALID = '0; EPOCH = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({TR, VL, SW, START, END, train_en, busy, epoch_cnt, sample_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {TR, VL, SW, START, END, train_en, busy, epoch_cnt, sample_cnt});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();      do_run(3, 2, 1, 0, 0, 0, "basic");       endtask
    task automatic test_multi_epoch(); do_run(2, 1, 3, 1, 0, 0, "multi_epoch"); endtask
    task automatic test_zero_epoch(); do_run(4, 4, 0, 0, 0, 0, "zero_epoch");  endtask
    task automatic test_no_train();   do_run(0, 2, 2, 0, 0, 0, "no_train");    endtask
    task automatic test_no_samples(); do_run(0, 0, 2, 0, 0, 0, "no_samples");  endtask
    task automatic test_slow_handshake(); do_run(2, 0, 1, 5, 0, 0, "slow_hs"); endtask
    task automatic test_stray_done(); do_run(2, 2, 1, 3, 1, 0, "stray_done");  endtask
    task automatic test_held_done();  do_run(3, 2, 2, 0, 0, 1, "held_done");   endtask

    task automatic test_abort();
        int  g, wcnt, state_n;
        bit  hit;
        @(negedge clk);
        TRAIN = 16'd2; VALID = 16'd2; EPOCH = 16'd3;
        g = cyc + 1;
        push_run(2, 2, 3, 1, g, 8);
        go = 1'b1; wcnt = -1; hit = 0; state_n = 0;
        for (int i = 0; i < 500 && state_n < 2; i++) begin
            @(negedge clk);
            go = 1'b0;
            arch_done = 1'b0;
            if (state_n == 1) begin
                rst = 1'b1; state_n = 2;
            end else if (TR === 1'b1 || VL === 1'b1) begin
                wcnt = 1;
                if (VL === 1'b1 && epoch_cnt === 16'd1) state_n = 1;
            end else if (wcnt == 0) begin
                arch_done = 1'b1; wcnt = -1;
            end else if (wcnt > 0) wcnt--;
        end
        @(negedge clk);
        vectors++;
        if (state_n != 2) begin
            errors++;
            $display("FAIL abort_timeout: epoch 1 validation never reached");
        end else if ({TR, VL, SW, START, END, train_en, busy, epoch_cnt, sample_cnt} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %b, required all zero",
                     {TR, VL, SW, START, END, train_en, busy, epoch_cnt, sample_cnt});
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (sb.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_residue: %0d pending pulses, busy=%b, required 0 and 0", sb.size(), busy);
        end
        sb.delete();
        do_run(2, 2, 3, 1, 0, 0, "restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_epoch();
        test_zero_epoch();
        test_no_train();
        test_no_samples();
        test_slow_handshake();
        test_stray_done();
        test_held_done();
        test_abort();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nn_control.md
# nn_control

Sequencing controller for the neural-network training flow. It sits directly upstream of the Pattern block and drives its `TR`, `VL`, `SW`, `START` and `END` inputs. It reads the sample and epoch counts that Pattern publishes (`TRAIN`, `VALID`, `EPOCH`). It paces one sample at a time against a per-sample completion pulse from the Architecture block, and runs training, then validation, for every epoch before the final weight store.

## Interface
- `BITS`, 16, width of the count inputs and progress counters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; forces IDLE and clears all registers.
- `go`  in  1  run request; sampled only in IDLE.
- `TRAIN`  in  BITS  number of training samples per epoch (from Pattern).
- `VALID`  in  BITS  number of validation samples per epoch (from Pattern).
- `EPOCH`  in  BITS  number of epochs (from Pattern).
- `arch_done`  in  1  Architecture finished the current sample; sampled only in the WAIT states.
- `TR`  out  1  one-cycle pulse: advance to the next training sample (to Pattern).
- `VL`  out  1  one-cycle pulse: advance to the next validation sample (to Pattern).
- `SW`  out  1  one-cycle pulse: store weights (to Pattern).
- `START`  out  1  one-cycle pulse at run start (to Pattern).
- `END`  out  1  one-cycle pulse at run completion (to Pattern).
- `train_en`  out  1  high while in the training states; Architecture applies weight updates only when this is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `epoch_cnt`  out  BITS  index of the current epoch, starting at 0.
- `sample_cnt`  out  BITS  index of the current sample within the current phase.

## Operation
- States: IDLE, STRT, T_ISSUE, T_WAIT, V_ISSUE, V_WAIT, STORE, FIN.
- Outputs are Moore outputs, each decoded from the state register only:
  - `START` = STRT, `TR` = T_ISSUE, `VL` = V_ISSUE, `SW` = STORE, `END` = FIN.
  - `train_en` = T_ISSUE or T_WAIT.
- IDLE: on `go`=1, go to STRT. `go` is ignored in every other state.
- STRT: clear `epoch_cnt` and `sample_cnt`, then branch:
  - `EPOCH`=0: go to STORE.
  - otherwise, `TRAIN`≠0: go to T_ISSUE.
  - otherwise, `VALID`≠0: go to V_ISSUE.
  - otherwise: go to STORE.
- T_ISSUE: unconditionally go to T_WAIT.
- T_WAIT: hold until `arch_done`=1, then:
  - `sample_cnt` < `TRAIN`-1: increment `sample_cnt`, go to T_ISSUE.
  - otherwise: clear `sample_cnt`, then go to V_ISSUE if `VALID`≠0, else do end-of-epoch.
- V_ISSUE and V_WAIT: same structure as the training pair, counting against `VALID`; after the last sample, do end-of-epoch.
- End-of-epoch:
  - `epoch_cnt` < `EPOCH`-1: increment `epoch_cnt`, clear `sample_cnt`, go to T_ISSUE (or V_ISSUE if `TRAIN`=0).
  - otherwise: go to STORE.
- STORE goes to FIN; FIN goes to IDLE.
- `arch_done` is ignored outside T_WAIT and V_WAIT. A level held high in a WAIT state counts once per visit.
- `TRAIN`, `VALID` and `EPOCH` are read live; they must stay constant while `busy`=1.
- Counter compares are unsigned at `BITS` width. Counters never wrap: the maximum count is 2^BITS−1.

## Timing
- Reset: after the `rst` edge, state is IDLE and every output is 0, counters included. A `rst` mid-run aborts the run with no `SW` and no `END` pulse.
- `rst` has priority over every other input in the same cycle.
- Latency from `go`:
  - `go` sampled at edge k gives `START` high in cycle k+1.
  - The first `TR` is high in cycle k+2.
- Pattern presents the new sample the cycle after `TR` or `VL`. `arch_done` may therefore be asserted no earlier than that cycle.
- Maximum throughput is 2 cycles per sample: `arch_done` arriving in the first WAIT cycle gives the next `TR` in the following cycle.
- `SW` is followed by `END` in the next cycle. `busy` falls in the cycle after `END`.
- Only one of `TR`, `VL`, `SW`, `START` or `END` is high in any cycle.

## Test plan
- TRAIN=3, VALID=2, EPOCH=1, `arch_done` pulsed in the first WAIT cycle:
  - Pulse order is START, TR×3, VL×2, SW, END, each TR and VL 2 cycles apart.
  - `busy` is high for 13 cycles.
- TRAIN=2, VALID=1, EPOCH=3: 6 TR and 3 VL pulses in the order TR TR VL, repeated 3 times; `epoch_cnt` steps 0, 1, 2; a single SW.
- EPOCH=0: START, SW, END in consecutive cycles; no TR or VL.
- TRAIN=0, VALID=2, EPOCH=2: VL×4 with no TR; `train_en` is never high.
- Handshake timing:
  - `arch_done` held low for 5 cycles in T_WAIT: state holds, and TR re-fires only after `arch_done`.
  - `arch_done` high during T_ISSUE: ignored.
- `rst` asserted in V_WAIT in the middle of epoch 1:
  - All outputs are 0 in the next cycle; no SW or END.
  - A following `go` restarts from epoch 0 with a START pulse.
